// File: rtl/dmem_responder.sv
// Multi-cycle data memory: one load/store per handshake, response after LATENCY.
// Word-addressed internal storage; addresses above the implemented depth error out.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_we/req_addr/req_wdata request fields (1 = store)
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata/rsp_err         load data or store echo; out-of-range flag
//   busy                      high whenever a transaction is in flight
module dmem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_W    = 16,
    parameter int LATENCY   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [15:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t stateNext;

    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cntNext;

    logic                 latWe;
    logic [ADDR_BITS-1:0] latIdx;
    logic [DATA_W-1:0]    latWdata;
    logic                 latErr;

    logic [DATA_W-1:0]    rspRdata;
    logic                 rspErr;

    logic                 accept;
    logic                 commit;

    logic                 cmtWe;
    logic [ADDR_BITS-1:0] cmtIdx;
    logic [DATA_W-1:0]    cmtWdata;
    logic                 cmtErr;

    logic                 reqErr;

    logic [DATA_W-1:0]    mem [DEPTH];

    // Any address bit above the implemented index makes the access illegal.
    assign reqErr = (req_addr >> ADDR_BITS) != 16'd0;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign rsp_rdata = rspRdata;
    assign rsp_err   = rspErr;

    // With LATENCY == 1 the commit happens on the accept edge itself,
    // so the live request fields feed the memory instead of the latches.
    always_comb begin
        cmtWe    = latWe;
        cmtIdx   = latIdx;
        cmtWdata = latWdata;
        cmtErr   = latErr;
        if (state == IDLE) begin
            cmtWe    = req_we;
            cmtIdx   = req_addr[ADDR_BITS-1:0];
            cmtWdata = req_wdata;
            cmtErr   = reqErr;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        accept    = 1'b0;
        commit    = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        stateNext = RESP;
                        commit    = 1'b1;
                    end else begin
                        stateNext = WAIT;
                        cntNext   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    stateNext = RESP;
                    commit    = 1'b1;
                end else begin
                    cntNext = cnt - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            latWe    <= 1'b0;
            latIdx   <= '0;
            latWdata <= '0;
            latErr   <= 1'b0;
        end else if (accept) begin
            latWe    <= req_we;
            latIdx   <= req_addr[ADDR_BITS-1:0];
            latWdata <= req_wdata;
            latErr   <= reqErr;
        end
    end

    // Response registers load once, on the edge entering RESP, and hold
    // until the next commit so the payload is stable while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            rspRdata <= '0;
            rspErr   <= 1'b0;
        end else if (commit) begin
            rspErr <= cmtErr;
            if (cmtWe) begin
                rspRdata <= cmtWdata;
            end else if (cmtErr) begin
                rspRdata <= '0;
            end else begin
                rspRdata <= mem[cmtIdx];
            end
        end
    end

    // Storage is never cleared; an aborted or illegal store never lands.
    always_ff @(posedge clk) begin
        if (!rst && commit && cmtWe && !cmtErr) begin
            mem[cmtIdx] <= cmtWdata;
        end
    end

endmodule
